// File: rtl/fetch_pc_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_pc_ctrl
// -----------------------------------------------------------------------------
// Sequences the instruction-fetch stage of the P5 pipeline.
//   * Owns the fetch PC and issues one request at a time to a multi-cycle
//     instruction memory over a level req / single-cycle ack handshake.
//   * Presents fetched words on the F/D boundary through an output register
//     backed by a one-entry skid buffer. When both are full the controller
//     stops requesting until the decode stage drains.
//   * Applies D-stage redirects with branch-delay-slot semantics. The request
//     that is in flight when a redirect is accepted completes and is
//     delivered, and fetch then resumes at the redirect target.
//
// Optional feature macro: PC_ALIGN_CHK_EN
//   defined   : an accepted redirect whose target has nonzero bits [1:0] sets
//               the sticky misalign_o flag. The controller then enters HALT:
//               no further requests are issued and the output registers drain
//               normally.
//   undefined : redirect targets are forced word aligned, misalign_o is tied
//               0, and HALT does not exist.
//
// Parameters
//   RESET_PC       fetch address loaded on reset (bits [1:0] must be 0)
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   stall_i        hazard stall, F/D must not advance
//   redir_valid_i  D-stage redirect strobe (accepted only when stall_i=0)
//   redir_pc_i     redirect target
//   imem_req_o     instruction memory request (level, registered)
//   imem_addr_o    request address (held stable until ack)
//   imem_ack_i     single-cycle acknowledge, imem_rdata_i valid with it
//   imem_rdata_i   fetched instruction word
//   if_valid_o     F/D payload valid
//   if_instr_o     fetched instruction
//   if_pc_o        PC of if_instr_o
//   if_pc4_o       if_pc_o + 4
//   misalign_o     sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redir_valid_i,
    input  logic [31:0] redir_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_pc4_o,
    output logic        misalign_o
);

`ifdef PC_ALIGN_CHK_EN
    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_REQ  = 2'b01,
        ST_HOLD = 2'b10,
        ST_HALT = 2'b11
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_REQ  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;
`endif

    // Controller state and fetch PC
    state_t      state_r;
    logic        req_r;
    logic [31:0] pc_r;

    // Redirect accepted while the delay-slot request is still outstanding
    logic        pend_v_r;
    logic [31:0] pend_pc_r;

    // One-entry skid buffer, filled only when an ack lands on a stalled,
    // already-full output register
    logic        skid_v_r;
    logic [31:0] skid_instr_r;
    logic [31:0] skid_pc_r;

    // F/D output registers
    logic        out_v_r;
    logic [31:0] out_instr_r;
    logic [31:0] out_pc_r;
    logic [31:0] out_pc4_r;

`ifdef PC_ALIGN_CHK_EN
    logic        misalign_r;
    logic        redir_bad_s;
`endif

    // Combinational helpers
    logic        redir_acc_s;
    logic [31:0] redir_pc_s;
    logic        ack_s;
    logic        out_free_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] skid_pc4_s;
    logic [31:0] ack_next_pc_s;

    assign redir_acc_s = redir_valid_i & ~stall_i;
`ifdef PC_ALIGN_CHK_EN
    assign redir_pc_s  = redir_pc_i;
    assign redir_bad_s = redir_acc_s & (redir_pc_i[1:0] != 2'b00);
`else
    // Targets are word addresses; the low bits are simply discarded.
    assign redir_pc_s  = redir_pc_i & 32'hFFFF_FFFC;
`endif

    // An ack is meaningful only while a request is actually on the bus.
    assign ack_s       = imem_ack_i & req_r;
    // The output register can take new data if it is empty or being consumed.
    assign out_free_s  = ~out_v_r | ~stall_i;
    assign pc_plus4_s  = pc_r + 32'd4;
    assign skid_pc4_s  = skid_pc_r + 32'd4;

    // Next fetch PC after an ack: a same-cycle redirect beats a pending one,
    // which beats sequential fetch.
    always_comb begin
        ack_next_pc_s = pc_plus4_s;
        if (redir_acc_s) begin
            ack_next_pc_s = redir_pc_s;
        end else if (pend_v_r) begin
            ack_next_pc_s = pend_pc_r;
        end else begin
            ack_next_pc_s = pc_plus4_s;
        end
    end

    // Fetch FSM: PC, pending redirect, skid buffer and F/D output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_BOOT;
            req_r        <= 1'b0;
            pc_r         <= RESET_PC;
            pend_v_r     <= 1'b0;
            pend_pc_r    <= 32'd0;
            skid_v_r     <= 1'b0;
            skid_instr_r <= 32'd0;
            skid_pc_r    <= 32'd0;
            out_v_r      <= 1'b0;
            out_instr_r  <= 32'd0;
            out_pc_r     <= 32'd0;
            out_pc4_r    <= 32'd0;
`ifdef PC_ALIGN_CHK_EN
            misalign_r   <= 1'b0;
`endif
        end else begin
            // Decode consumes the current payload whenever it is not stalled;
            // any load below overrides this.
            if (!stall_i) begin
                out_v_r <= 1'b0;
            end else begin
                out_v_r <= out_v_r;
            end

            case (state_r)
                ST_BOOT: begin
                    // One idle cycle after reset; a late ack is ignored here.
                    state_r <= ST_REQ;
                    req_r   <= 1'b1;
                    if (redir_acc_s) begin
                        pc_r <= redir_pc_s;
                    end
                end

                ST_REQ: begin
                    if (ack_s) begin
                        if (out_free_s) begin
                            out_v_r     <= 1'b1;
                            out_instr_r <= imem_rdata_i;
                            out_pc_r    <= pc_r;
                            out_pc4_r   <= pc_plus4_s;
                        end else begin
                            // Decode is stalled on a full output: park the word
                            // and stop requesting until it drains.
                            skid_v_r     <= 1'b1;
                            skid_instr_r <= imem_rdata_i;
                            skid_pc_r    <= pc_r;
                            state_r      <= ST_HOLD;
                            req_r        <= 1'b0;
                        end
                        pc_r     <= ack_next_pc_s;
                        pend_v_r <= 1'b0;
                    end else if (redir_acc_s) begin
                        // The outstanding request is the delay slot; remember
                        // the target until it completes (last redirect wins).
                        pend_v_r  <= 1'b1;
                        pend_pc_r <= redir_pc_s;
                    end
                end

                ST_HOLD: begin
                    if (!stall_i) begin
                        out_v_r     <= skid_v_r;
                        out_instr_r <= skid_instr_r;
                        out_pc_r    <= skid_pc_r;
                        out_pc4_r   <= skid_pc4_s;
                        skid_v_r    <= 1'b0;
                        state_r     <= ST_REQ;
                        req_r       <= 1'b1;
                    end
                    if (redir_acc_s) begin
                        pc_r <= redir_pc_s;
                    end
                end

`ifdef PC_ALIGN_CHK_EN
                ST_HALT: begin
                    // Terminal until reset: only the output registers drain.
                    req_r <= 1'b0;
                end
`endif

                default: begin
                    state_r  <= ST_BOOT;
                    req_r    <= 1'b0;
                    pend_v_r <= 1'b0;
                    skid_v_r <= 1'b0;
                end
            endcase

`ifdef PC_ALIGN_CHK_EN
            // A misaligned target stops fetch for good. Any word acked in the
            // same cycle has already been routed to the output or skid above.
            if (redir_bad_s && (state_r != ST_HALT)) begin
                misalign_r <= 1'b1;
                state_r    <= ST_HALT;
                req_r      <= 1'b0;
                pend_v_r   <= 1'b0;
            end
`endif
        end
    end

    assign imem_req_o  = req_r;
    assign imem_addr_o = pc_r;
    assign if_valid_o  = out_v_r;
    assign if_instr_o  = out_instr_r;
    assign if_pc_o     = out_pc_r;
    assign if_pc4_o    = out_pc4_r;
`ifdef PC_ALIGN_CHK_EN
    assign misalign_o  = misalign_r;
`else
    assign misalign_o  = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_ctrl
// Self-checking bench for fetch_pc_ctrl. A transaction-level reference model
// tracks the architectural fetch stream: a FIFO of fetched-but-unconsumed
// PCs (depth 2 = output register + skid), the next fetch address and a
// pending redirect target. Memory contents are a fixed hash of the address.
// -----------------------------------------------------------------------------
module tb_fetch_pc_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redir_valid_i;
    logic [31:0] redir_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc4_o;
    logic        misalign_o;

    fetch_pc_ctrl #(.RESET_PC(32'h0000_3000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redir_valid_i (redir_valid_i),
        .redir_pc_i    (redir_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_instr_o    (if_instr_o),
        .if_pc_o       (if_pc_o),
        .if_pc4_o      (if_pc4_o),
        .misalign_o    (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PC_ALIGN_CHK_EN
    localparam bit MIS_IN_RANDOM = 1'b0;
`else
    localparam bit MIS_IN_RANDOM = 1'b1;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] q_pc[$];      // fetched words awaiting consumption, oldest first
    bit          booted;       // idle cycle after reset has elapsed
    bit          halted;
    bit          exp_mis;
    logic [31:0] next_addr;    // address of the current / next request
    bit          have_target;  // redirect waiting for the in-flight request
    logic [31:0] target;
    int          wait_cnt;     // memory latency countdown

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        q_pc.delete();
        booted      = 1'b0;
        halted      = 1'b0;
        exp_mis     = 1'b0;
        next_addr   = 32'h0000_3000;
        have_target = 1'b0;
        target      = 32'd0;
        wait_cnt    = int'($urandom_range(0, 2));
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", {31'd0, if_valid_o}, 32'd0);
        check("rst_instr", if_instr_o, 32'd0);
        check("rst_pc", if_pc_o, 32'd0);
        check("rst_pc4", if_pc4_o, 32'd0);
        check("rst_req", {31'd0, imem_req_o}, 32'd0);
        check("rst_misalign", {31'd0, misalign_o}, 32'd0);
    endtask

    task automatic check_outputs();
        bit exp_req;
        exp_req = booted && (q_pc.size() < 2) && !halted;
        check("valid", {31'd0, if_valid_o}, {31'd0, (q_pc.size() > 0)});
        if (q_pc.size() > 0) begin
            check("if_pc", if_pc_o, q_pc[0]);
            check("if_pc4", if_pc4_o, q_pc[0] + 32'd4);
            check("if_instr", if_instr_o, mem_word(q_pc[0]));
        end
        check("req", {31'd0, imem_req_o}, {31'd0, exp_req});
        if (exp_req) begin
            check("addr", imem_addr_o, next_addr);
        end
        check("misalign", {31'd0, misalign_o}, {31'd0, exp_mis});
    endtask

    // Drive one cycle of random stimulus and advance the model past the
    // next rising edge.
    task automatic drive_and_step(input int p_stall, input int p_redir,
                                  input int max_lat, input bit allow_mis);
        bit          exp_req, stall_v, redir_v, ack_v, acc_v, bad_v;
        logic [31:0] tgt_v, t_v, r_v;
        exp_req = booted && (q_pc.size() < 2) && !halted;
        stall_v = (int'($urandom_range(0, 99)) < p_stall);
        redir_v = (int'($urandom_range(0, 99)) < p_redir);
        r_v     = $urandom_range(0, 3);
        if (r_v == 32'd0) begin
            tgt_v = 32'hFFFF_FFF0 + ({$urandom_range(0, 3)} << 2);
        end else begin
            tgt_v = 32'h0000_3000 + ({$urandom_range(0, 255)} << 2);
        end
        if (allow_mis && ($urandom_range(0, 3) == 0)) begin
            r_v = $urandom_range(0, 3);
            tgt_v[1:0] = r_v[1:0];
        end
        if (exp_req) begin
            if (wait_cnt == 0) begin
                ack_v        = 1'b1;
                imem_rdata_i = mem_word(next_addr);
            end else begin
                ack_v        = 1'b0;
                imem_rdata_i = $urandom;
                wait_cnt--;
            end
        end else begin
            ack_v        = ($urandom_range(0, 7) == 0);  // stray ack, must be ignored
            imem_rdata_i = $urandom;
        end
        stall_i       = stall_v;
        redir_valid_i = redir_v;
        redir_pc_i    = tgt_v;
        imem_ack_i    = ack_v;

        acc_v = redir_v && !stall_v;
`ifdef PC_ALIGN_CHK_EN
        t_v   = tgt_v;
        bad_v = acc_v && (tgt_v[1:0] != 2'b00);
`else
        t_v   = tgt_v & 32'hFFFF_FFFC;
        bad_v = 1'b0;
`endif
        if ((q_pc.size() > 0) && !stall_v) begin
            void'(q_pc.pop_front());
        end
        if (acc_v && !halted) begin
            if (bad_v) begin
                halted  = 1'b1;
                exp_mis = 1'b1;
            end else if (exp_req) begin
                have_target = 1'b1;
                target      = t_v;
            end else begin
                next_addr = t_v;
            end
        end
        if (ack_v && exp_req) begin
            q_pc.push_back(next_addr);
            next_addr   = have_target ? target : (next_addr + 32'd4);
            have_target = 1'b0;
            wait_cnt    = int'($urandom_range(0, max_lat));
        end
        booted = 1'b1;
    endtask

    task automatic run_phase(input int n, input int p_stall, input int p_redir,
                             input int max_lat, input bit allow_mis);
        for (int i = 0; i < n; i++) begin
            check_outputs();
            drive_and_step(p_stall, p_redir, max_lat, allow_mis);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        stall_i       = 1'b0;
        redir_valid_i = 1'b0;
        redir_pc_i    = 32'd0;
        imem_ack_i    = 1'b0;
        imem_rdata_i  = 32'd0;
        reset_model();
        wait_cnt = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // Zero-wait memory, no stalls: one sequential word per cycle
        run_phase(20, 0, 0, 0, MIS_IN_RANDOM);
        // Mixed latency, moderate stalls and redirects
        run_phase(400, 30, 10, 3, MIS_IN_RANDOM);
        // Heavy stall pressure to exercise the skid buffer
        run_phase(300, 70, 8, 2, MIS_IN_RANDOM);

        // Reset in the middle of traffic, then a late ack right after release
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        imem_ack_i   = 1'b1;
        imem_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        reset_model();
        check_outputs();
        stall_i       = 1'b0;
        redir_valid_i = 1'b0;
        imem_ack_i    = 1'b1;
        booted        = 1'b1;
        @(negedge clk);
        imem_ack_i = 1'b0;

        // Redirect-heavy traffic including targets near the top of memory
        run_phase(300, 25, 30, 1, MIS_IN_RANDOM);
`ifdef PC_ALIGN_CHK_EN
        // Misaligned targets allowed: fetch must halt with the flag set
        run_phase(150, 20, 30, 1, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Sequences the IF stage of the P5 pipeline.
- Owns the fetch PC register and issues requests to a multi-cycle instruction memory over a req/ack handshake.
- Presents fetched instructions to the F/D boundary with a one-entry skid buffer.
- Applies D-stage redirects (jump/branch targets from the next-PC logic) with branch-delay-slot semantics.

Parameters:
- RESET_PC, 32'h0000_3000, fetch address loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_i  in  1  hazard-unit stall: F/D register must not advance.
- redir_valid_i  in  1  D-stage redirect strobe; sampled only when stall_i=0.
- redir_pc_i  in  32  redirect target.
- imem_req_o  out  1  instruction memory request, level.
- imem_addr_o  out  32  request address.
- imem_ack_i  in  1  single-cycle acknowledge; imem_rdata_i valid in the same cycle.
- imem_rdata_i  in  32  fetched instruction word.
- if_valid_o  out  1  F/D payload valid.
- if_instr_o  out  32  fetched instruction.
- if_pc_o  out  32  PC of if_instr_o.
- if_pc4_o  out  32  if_pc_o+4.
- misalign_o  out  1  sticky misaligned-redirect flag; tied 0 unless PC_ALIGN_CHK_EN is defined.

Behaviour:
- Reset (async, rst_n=0):
  - pc_q=RESET_PC; state=BOOT; pend_v=0; skid_v=0.
  - All outputs 0: if_valid_o, if_instr_o, if_pc_o, if_pc4_o, imem_req_o, misalign_o.
  - Reset mid-request abandons the outstanding request; a late ack after reset deassertion is ignored because req=0 in BOOT.
- States:
  - BOOT: req=0; next state is always REQ, giving one idle cycle after reset.
  - REQ: imem_req_o=1, imem_addr_o=pc_q; both held stable until ack.
    - On ack with (if_valid_o=0 or stall_i=0): load the out regs with instr=rdata, pc=pc_q, pc4=pc_q+4; if_valid_o=1; remain in REQ, so the next request is issued the following cycle.
    - On ack with if_valid_o=1 and stall_i=1: capture into the skid register; state becomes HOLD.
    - On every ack: pc_q <= pend_v ? pend_pc : pc_q+4; pend_v is cleared.
  - HOLD: req=0. When stall_i=0, the skid entry moves to the out regs, skid_v is cleared and state becomes REQ.
- Out-register consumption:
  - When stall_i=0 and no new data is loading, if_valid_o falls to 0 at the edge.
  - When stall_i=1, the out regs hold their value.
- Redirect, accepted only when redir_valid_i=1 and stall_i=0:
  - REQ without ack in the same cycle: pend_pc=redir_pc_i, pend_v=1. The outstanding request (the delay slot) completes, then fetch resumes at the target.
  - REQ with ack in the same cycle: the acked word is the delay slot and is kept; pc_q <= redir_pc_i.
  - BOOT or HOLD: pc_q <= redir_pc_i directly.
  - A second redirect while pend_v=1 overwrites pend_pc (last wins).
- Ack while imem_req_o=0 is ignored.
- PC arithmetic is 32-bit unsigned with wrap-around: 32'hFFFF_FFFC+4 = 0.
- Throughput: one instruction per memory latency+1 cycles; with zero-wait memory (ack in the same cycle as req), one instruction every cycle.

Optional Feature:
- Macro: PC_ALIGN_CHK_EN.
- Defined: an accepted redirect with redir_pc_i[1:0]!=0 sets misalign_o=1 (sticky until reset) and moves the controller to state HALT.
  - HALT: req=0; out regs drain normally; no further fetches.
- Undefined: redir_pc_i[1:0] is forced to 2'b00; misalign_o is tied 0; no HALT state exists.

Test Plan:
- Reset release, ack after 2 cycles, stall_i=0 -> first req at cycle 1 with addr 0x3000; if_pc_o=0x3000, if_pc4_o=0x3004; next req addr 0x3004.
- Zero-wait memory, 4 acks -> if_pc_o sequence 0x3000, 0x3004, 0x3008, 0x300C on consecutive cycles.
- stall_i=1 for 3 cycles with out full, ack arrives -> skid captured, state HOLD, req=0; on stall release out=skid word, req resumes.
- Redirect to 0x3100 while req outstanding (no ack) -> delay slot at 0x3004 delivered, next req addr 0x3100.
- Redirect 0x3200 in the same cycle as ack of 0x3008 -> 0x3008 delivered, next addr 0x3200; redirect with stall_i=1 -> ignored.
- PC_ALIGN_CHK_EN defined, redirect 0x3102 -> misalign_o=1, no further req. Undefined: next addr 0x3100, misalign_o=0.
